// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction decoder.
// Holds opcode/funct constants, ALU operation encodings, ctrl bit indices
// (with matching one-hot masks) and a small immediate sign-extension helper.
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU_NOP doubles as the "no operation / illegal" encoding.
    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_SLT = 4'd5
    } alu_op_e;

    // ctrl = {reg_wr, mem_rd, mem_wr, alu_src, reg_dst, branch, jump, illegal}
    localparam int CTRL_REG_WR  = 7;
    localparam int CTRL_MEM_RD  = 6;
    localparam int CTRL_MEM_WR  = 5;
    localparam int CTRL_ALU_SRC = 4;
    localparam int CTRL_REG_DST = 3;
    localparam int CTRL_BRANCH  = 2;
    localparam int CTRL_JUMP    = 1;
    localparam int CTRL_ILLEGAL = 0;

    localparam logic [7:0] M_REG_WR  = 8'(1) << CTRL_REG_WR;
    localparam logic [7:0] M_MEM_RD  = 8'(1) << CTRL_MEM_RD;
    localparam logic [7:0] M_MEM_WR  = 8'(1) << CTRL_MEM_WR;
    localparam logic [7:0] M_ALU_SRC = 8'(1) << CTRL_ALU_SRC;
    localparam logic [7:0] M_REG_DST = 8'(1) << CTRL_REG_DST;
    localparam logic [7:0] M_BRANCH  = 8'(1) << CTRL_BRANCH;
    localparam logic [7:0] M_JUMP    = 8'(1) << CTRL_JUMP;
    localparam logic [7:0] M_ILLEGAL = 8'(1) << CTRL_ILLEGAL;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one synchronous write port.
// Register 0 always reads as zero and ignores writes. Synchronous active-high
// reset clears every entry and drops any write presented in the same cycle.
// Optional feature macro: INSTR_DEC_BYPASS_EN -- when defined, a write that
// targets the address being read is forwarded to the read data in the same
// cycle; otherwise reads return the pre-write contents.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   ra_addr / ra_data        read port A
//   rb_addr / rb_data        read port B
//   wr_en / wr_addr / wr_data write port
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int RF_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [4:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [RF_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != 5'd0 && int'(wr_addr) < RF_DEPTH) begin
            regs[wr_addr] <= wr_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
        logic [DATA_W-1:0] v;
        v = '0;
        if (addr != 5'd0 && int'(addr) < RF_DEPTH) begin
            v = regs[addr];
        end
`ifdef INSTR_DEC_BYPASS_EN
        if (wr_en && wr_addr == addr && addr != 5'd0) begin
            v = wr_data;
        end
`endif
        return v;
    endfunction

    assign ra_data = read_port(ra_addr);
    assign rb_data = read_port(rb_addr);

endmodule

// File: rtl/instr_dec.sv
// Instruction decode stage: ID pipeline register, field/control decode,
// register-file read and load-use hazard detection (one-cycle stall).
// Optional feature macro: INSTR_DEC_BYPASS_EN (write-through bypass in reg_file).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   instr, instr_vld                fetched instruction and its valid
//   stall, flush                    hold / bubble the ID register
//   wb_en, wb_addr, wb_data         register-file write port
//   rs_addr, rt_addr, rd_addr       decoded register fields
//   rs_data, rt_data                register-file read data
//   imm_ext                         sign-extended imm16, or zero-extended j target
//   ctrl, alu_op                    control vector and ALU op (zero when not valid)
//   dec_vld                         decoded outputs valid
//   hazard                          load-use stall request to fetch
module instr_dec
    import isa_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RF_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_vld,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [31:0]       imm_ext,
    output logic [7:0]        ctrl,
    output logic [3:0]        alu_op,
    output logic              dec_vld,
    output logic              hazard
);

    logic [31:0] id_instr;
    logic        id_vld;
    logic        lp_vld;
    logic [4:0]  lp_rt;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [7:0]  ctrl_raw;
    alu_op_e     alu_raw;
    logic        is_lw;
    logic        reads_rt;
    logic        id_hold;

    assign opcode  = id_instr[31:26];
    assign rs_addr = id_instr[25:21];
    assign rt_addr = id_instr[20:16];
    assign rd_addr = id_instr[15:11];
    assign funct   = id_instr[5:0];

    assign imm_ext = (opcode == OP_J) ? {6'b0, id_instr[25:0]} : sign_ext16(id_instr[15:0]);

    always_comb begin
        ctrl_raw = '0;
        alu_raw  = ALU_NOP;
        is_lw    = 1'b0;
        reads_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_raw = ALU_ADD;
                    FN_SUB:  alu_raw = ALU_SUB;
                    FN_AND:  alu_raw = ALU_AND;
                    FN_OR:   alu_raw = ALU_OR;
                    FN_SLT:  alu_raw = ALU_SLT;
                    default: alu_raw = ALU_NOP;
                endcase
                if (alu_raw != ALU_NOP) begin
                    ctrl_raw = M_REG_WR | M_REG_DST;
                    reads_rt = 1'b1;
                end else begin
                    ctrl_raw = M_ILLEGAL;
                end
            end
            OP_ADDI: begin
                ctrl_raw = M_REG_WR | M_ALU_SRC;
                alu_raw  = ALU_ADD;
            end
            OP_LW: begin
                ctrl_raw = M_REG_WR | M_MEM_RD | M_ALU_SRC;
                alu_raw  = ALU_ADD;
                is_lw    = 1'b1;
            end
            OP_SW: begin
                ctrl_raw = M_MEM_WR | M_ALU_SRC;
                alu_raw  = ALU_ADD;
                reads_rt = 1'b1;
            end
            OP_BEQ: begin
                ctrl_raw = M_BRANCH;
                alu_raw  = ALU_SUB;
                reads_rt = 1'b1;
            end
            OP_J: begin
                ctrl_raw = M_JUMP;
            end
            default: begin
                ctrl_raw = M_ILLEGAL;
            end
        endcase
    end

    // rt only counts as a source for instructions that actually read it;
    // addi/lw use rt as their destination.
    assign hazard  = lp_vld && id_vld && (lp_rt != 5'd0)
                     && ((rs_addr == lp_rt) || (reads_rt && rt_addr == lp_rt));
    assign dec_vld = id_vld && !hazard;
    assign ctrl    = dec_vld ? ctrl_raw : 8'h00;
    assign alu_op  = dec_vld ? alu_raw : ALU_NOP;
    assign id_hold = hazard || stall;

    // load_pending clears on any hold, which bounds a hazard to one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_instr <= '0;
            id_vld   <= 1'b0;
            lp_vld   <= 1'b0;
            lp_rt    <= '0;
        end else if (flush) begin
            id_instr <= '0;
            id_vld   <= 1'b0;
            lp_vld   <= 1'b0;
            lp_rt    <= '0;
        end else if (id_hold) begin
            lp_vld   <= 1'b0;
            lp_rt    <= '0;
        end else begin
            id_instr <= instr;
            id_vld   <= instr_vld;
            lp_vld   <= is_lw && dec_vld;
            lp_rt    <= rt_addr;
        end
    end

    reg_file #(
        .DATA_W   (DATA_W),
        .RF_DEPTH (RF_DEPTH)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (rs_addr),
        .ra_data (rs_data),
        .rb_addr (rt_addr),
        .rb_data (rt_data),
        .wr_en   (wb_en),
        .wr_addr (wb_addr),
        .wr_data (wb_data)
    );

endmodule

// File: doc/instr_dec.md
INSTR_DEC -- requirements
Module: instr_dec

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width.
REQ-002 SHALL have parameter RF_DEPTH, default 32, register count; address width is 5.
REQ-003 SHALL operate on one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 instr  in  32  fetched instruction.
REQ-007 instr_vld  in  1  instr is valid this cycle.
REQ-008 stall  in  1  downstream hold; the ID register keeps its contents.
REQ-009 flush  in  1  loads a bubble into the ID register (branch/jump redirect).
REQ-010 wb_en / wb_addr / wb_data  in  1/5/32  register-file write port.
REQ-011 rs_addr / rt_addr / rd_addr  out  5 each  decoded register fields.
REQ-012 rs_data / rt_data  out  32 each  register-file read data.
REQ-013 imm_ext  out  32  sign-extended instr[15:0]; for j, the zero-extended instr[25:0].
REQ-014 ctrl  out  8  {reg_wr, mem_rd, mem_wr, alu_src, reg_dst, branch, jump, illegal}.
REQ-015 alu_op  out  4  ALU operation code.
REQ-016 dec_vld  out  1  decoded outputs are valid.
REQ-017 hazard  out  1  load-use stall request to fetch.

Function
REQ-018 SHALL decode fields as follows: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0].
REQ-019 SHALL decode these opcodes: 0x00 R-type (funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j.
REQ-020 SHALL handle any other opcode or funct this way: ctrl = 8'b0000_0001 (illegal only), alu_op = 0, dec_vld still asserted.
REQ-021 SHALL have a latency of 1 cycle: instr captured at edge N drives decoded outputs during cycle N+1.
REQ-022 SHALL update the ID register on each rising edge, in this priority order: reset > flush (bubble, valid = 0) > hazard or stall (hold) > load {instr, instr_vld}.
REQ-023 SHALL drive dec_vld as ID valid AND NOT hazard; when dec_vld = 0, ctrl and alu_op SHALL read as zero.
REQ-024 SHALL read the register file combinationally from the ID register's rs/rt fields.
REQ-025 SHALL read register 0 as 0, and SHALL ignore writes to register 0.
REQ-026 SHALL perform register-file writes on the rising edge when wb_en = 1.
REQ-027 SHALL track load state: a load_pending register captures {is_lw AND dec_vld, rt} whenever the ID register advances.
REQ-028 SHALL clear load_pending when the ID register holds.
REQ-029 SHALL assert hazard = load_pending AND ID valid AND (rs_addr == pending_rt OR (rt_addr == pending_rt AND instruction reads rt)) AND pending_rt != 0.
REQ-030 SHALL limit a hazard to exactly one cycle, because load_pending clears on that hold.
REQ-031 SHALL, when flush and stall occur together, give flush priority; load_pending SHALL clear on flush.

Reset
REQ-032 SHALL clear on reset: ID register = 0, ID valid = 0, load_pending = 0, all register-file entries = 0.
REQ-033 SHALL, on reset, drive dec_vld = 0, hazard = 0, ctrl = 0, alu_op = 0.
REQ-034 SHALL discard any in-flight wb_en write during a reset cycle.

Configuration
REQ-035 SHALL compile in a write-through bypass when INSTR_DEC_BYPASS_EN is defined: if wb_en AND wb_addr == read address AND wb_addr != 0, rs_data/rt_data return wb_data in the same cycle.
REQ-036 SHALL, when INSTR_DEC_BYPASS_EN is undefined, return the pre-write register value; the write is visible the next cycle.

Structure
REQ-037 SHALL place opcode/funct constants, ALU op encodings and ctrl bit indices in shared package isa_pkg.
REQ-038 SHALL implement the register file as sub-module reg_file: two combinational read ports, one synchronous write port, synchronous reset.

Verification
REQ-039 Reset: assert reset for 2 cycles with instr_vld = 1 -> dec_vld = 0, hazard = 0, and reads of registers 1..31 return 0.
REQ-040 addi: wb r1 = 5, then instr = 0x20220003 (addi r2, r1, 3) -> next cycle rs_addr = 1, rs_data = 5, imm_ext = 3, ctrl reg_wr = 1 and alu_src = 1.
REQ-041 Load-use: lw r3, 0(r1) followed by add r4, r3, r1 -> hazard = 1 for exactly one cycle, then the add issues with dec_vld = 1.
REQ-042 Flush/stall: flush and stall asserted together -> next cycle dec_vld = 0; with stall alone, outputs stay unchanged for the duration of the stall.
REQ-043 Bypass: wb_en to r7 = 0xDEAD_BEEF in the same cycle the ID register reads r7 -> rs_data = 0xDEAD_BEEF if the macro is defined, old value otherwise; a write to r0 still reads 0.
REQ-044 Illegal: opcode 0x3F -> ctrl = 0x01 and dec_vld = 1.
